// File: rtl/ctrl_defs.sv
// Shared decode constants for the ID stage: opcode/function fields, ALUOp
// encodings, control-field encodings and the registered control bundle type.
package ctrl_defs;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_MADD     = 6'h1C;
  localparam logic [5:0] OP_LA       = 6'h1D;
  localparam logic [5:0] OP_SPECIAL3 = 6'h1F;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;
  localparam logic [5:0] OP_EXI      = 6'h3F;

  localparam logic [5:0] FUNC_SLL   = 6'h00;
  localparam logic [5:0] FUNC_SRL   = 6'h02;
  localparam logic [5:0] FUNC_SRA   = 6'h03;
  localparam logic [5:0] FUNC_SLLV  = 6'h04;
  localparam logic [5:0] FUNC_SRLV  = 6'h06;
  localparam logic [5:0] FUNC_SRAV  = 6'h07;
  localparam logic [5:0] FUNC_JR    = 6'h08;
  localparam logic [5:0] FUNC_ADD   = 6'h20;
  localparam logic [5:0] FUNC_ADDU  = 6'h21;
  localparam logic [5:0] FUNC_SUB   = 6'h22;
  localparam logic [5:0] FUNC_SUBU  = 6'h23;
  localparam logic [5:0] FUNC_AND   = 6'h24;
  localparam logic [5:0] FUNC_OR    = 6'h25;
  localparam logic [5:0] FUNC_XOR   = 6'h26;
  localparam logic [5:0] FUNC_NOR   = 6'h27;
  localparam logic [5:0] FUNC_SLT   = 6'h2A;
  localparam logic [5:0] FUNC_SLTU  = 6'h2B;
  localparam logic [5:0] FUNC_MADD  = 6'h00;
  localparam logic [5:0] FUNC_MUL   = 6'h02;
  localparam logic [5:0] FUNC_MSUB  = 6'h04;
  localparam logic [5:0] FUNC_BSHFL = 6'h20;
  localparam logic [4:0] SA_SEB     = 5'h10;
  localparam logic [4:0] SA_SEH     = 5'h18;

  localparam logic [5:0] ALUOP_NOP   = 6'd0;
  localparam logic [5:0] ALUOP_ADD   = 6'd1;
  localparam logic [5:0] ALUOP_ADDU  = 6'd2;
  localparam logic [5:0] ALUOP_SUB   = 6'd3;
  localparam logic [5:0] ALUOP_SUBU  = 6'd4;
  localparam logic [5:0] ALUOP_AND   = 6'd5;
  localparam logic [5:0] ALUOP_OR    = 6'd6;
  localparam logic [5:0] ALUOP_XOR   = 6'd7;
  localparam logic [5:0] ALUOP_NOR   = 6'd8;
  localparam logic [5:0] ALUOP_SLT   = 6'd9;
  localparam logic [5:0] ALUOP_SLTU  = 6'd10;
  localparam logic [5:0] ALUOP_SLL   = 6'd11;
  localparam logic [5:0] ALUOP_SRL   = 6'd12;
  localparam logic [5:0] ALUOP_SRA   = 6'd13;
  localparam logic [5:0] ALUOP_ROTR  = 6'd14;
  localparam logic [5:0] ALUOP_SLLV  = 6'd15;
  localparam logic [5:0] ALUOP_SRLV  = 6'd16;
  localparam logic [5:0] ALUOP_SRAV  = 6'd17;
  localparam logic [5:0] ALUOP_ROTRV = 6'd18;
  localparam logic [5:0] ALUOP_ADDI  = 6'd19;
  localparam logic [5:0] ALUOP_ADDIU = 6'd20;
  localparam logic [5:0] ALUOP_ANDI  = 6'd21;
  localparam logic [5:0] ALUOP_ORI   = 6'd22;
  localparam logic [5:0] ALUOP_XORI  = 6'd23;
  localparam logic [5:0] ALUOP_SLTI  = 6'd24;
  localparam logic [5:0] ALUOP_SLTIU = 6'd25;
  localparam logic [5:0] ALUOP_LUI   = 6'd26;
  localparam logic [5:0] ALUOP_MEM   = 6'd27;
  localparam logic [5:0] ALUOP_BEQ   = 6'd28;
  localparam logic [5:0] ALUOP_BNE   = 6'd29;
  localparam logic [5:0] ALUOP_BLEZ  = 6'd30;
  localparam logic [5:0] ALUOP_BGTZ  = 6'd31;
  localparam logic [5:0] ALUOP_BLTZ  = 6'd32;
  localparam logic [5:0] ALUOP_BGEZ  = 6'd33;
  localparam logic [5:0] ALUOP_JUMP  = 6'd34;
  localparam logic [5:0] ALUOP_JR    = 6'd35;
  localparam logic [5:0] ALUOP_MADD  = 6'd36;
  localparam logic [5:0] ALUOP_MSUB  = 6'd37;
  localparam logic [5:0] ALUOP_MUL   = 6'd38;
  localparam logic [5:0] ALUOP_SEB   = 6'd39;
  localparam logic [5:0] ALUOP_SEH   = 6'd40;
  localparam logic [5:0] ALUOP_EXI   = 6'd41;
  localparam logic [5:0] ALUOP_LA    = 6'd42;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  localparam logic [1:0] BS_WORD = 2'b00;
  localparam logic [1:0] BS_HALF = 2'b01;
  localparam logic [1:0] BS_BYTE = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC8 = 2'b10;

  typedef enum logic {ST_RUN, ST_MUL_BUSY} state_e;

  typedef struct packed {
    logic       alub_mux;
    logic [1:0] reg_dst;
    logic [5:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] byte_sig;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] write_reg;
  } ctrl_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use compare between the instruction in decode and the load in execute.
module hazard_unit (
  input  logic       [4:0] rs,
  input  logic       [4:0] rt,
  input  logic             uses_rt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic       [4:0] ex_write_reg,
  output logic             load_use
);

  assign load_use = ex_valid & ex_mem_read & (ex_write_reg != 5'd0) &
                    ((ex_write_reg == rs) | (uses_rt & (ex_write_reg == rt)));

endmodule

// File: rtl/id_control_stage.sv
// Registered ID stage: decodes IF/ID into the ID/EX control bundle, detects
// load-use hazards, holds the front end during multi-cycle multiplies.
module id_control_stage
  import ctrl_defs::*;
#(
  parameter int ALUOP_W    = 6,
  parameter int MUL_CYCLES = 3,
  parameter int ENABLE_EXT = 1,
  parameter int HAZARD_EN  = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [31:0]        Instr_i,
  input  logic               InstrValid_i,
  input  logic               Flush_i,
  output logic               Stall_o,
  output logic               Valid_o,
  output logic               ALUBMux_o,
  output logic [1:0]         RegDst_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic [1:0]         ByteSig_o,
  output logic               RegWrite_o,
  output logic [1:0]         MemToReg_o,
  output logic [4:0]         Rs_o,
  output logic [4:0]         Rt_o,
  output logic [4:0]         WriteReg_o,
  output logic               Illegal_o
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, sa;
  ctrl_t      dec;
  logic       dec_illegal, uses_rt, is_mul;

  ctrl_t      bundle_p1;
  logic       vld_p1, illegal_p1;
  state_e     state;
  logic [3:0] mul_cnt;
  logic       raw_hazard, load_use, stall, accept, issue;

  assign op    = Instr_i[31:26];
  assign rs    = Instr_i[25:21];
  assign rt    = Instr_i[20:16];
  assign rd    = Instr_i[15:11];
  assign sa    = Instr_i[10:6];
  assign funct = Instr_i[5:0];

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    uses_rt     = 1'b0;
    dec.rs      = rs;
    dec.rt      = rt;
    case (op)
      OP_RTYPE: begin
        uses_rt       = 1'b1;
        dec.reg_dst   = REGDST_RD;
        dec.reg_write = 1'b1;
        case (funct)
          FUNC_SLL:  dec.alu_op = ALUOP_SLL;
          FUNC_SRL:  dec.alu_op = Instr_i[21] ? ALUOP_ROTR : ALUOP_SRL;
          FUNC_SRA:  dec.alu_op = ALUOP_SRA;
          FUNC_SLLV: dec.alu_op = ALUOP_SLLV;
          FUNC_SRLV: dec.alu_op = Instr_i[6] ? ALUOP_ROTRV : ALUOP_SRLV;
          FUNC_SRAV: dec.alu_op = ALUOP_SRAV;
          FUNC_JR: begin
            dec.alu_op    = ALUOP_JR;
            dec.reg_write = 1'b0;
          end
          FUNC_ADD:  dec.alu_op = ALUOP_ADD;
          FUNC_ADDU: dec.alu_op = ALUOP_ADDU;
          FUNC_SUB:  dec.alu_op = ALUOP_SUB;
          FUNC_SUBU: dec.alu_op = ALUOP_SUBU;
          FUNC_AND:  dec.alu_op = ALUOP_AND;
          FUNC_OR:   dec.alu_op = ALUOP_OR;
          FUNC_XOR:  dec.alu_op = ALUOP_XOR;
          FUNC_NOR:  dec.alu_op = ALUOP_NOR;
          FUNC_SLT:  dec.alu_op = ALUOP_SLT;
          FUNC_SLTU: dec.alu_op = ALUOP_SLTU;
          default:   dec_illegal = 1'b1;
        endcase
      end
      OP_REGIMM: dec.alu_op = Instr_i[16] ? ALUOP_BGEZ : ALUOP_BLTZ;
      OP_J:      dec.alu_op = ALUOP_JUMP;
      OP_JAL: begin
        dec.alu_op     = ALUOP_JUMP;
        dec.reg_dst    = REGDST_R31;
        dec.mem_to_reg = M2R_PC8;
        dec.reg_write  = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_op = ALUOP_BEQ;
        uses_rt    = 1'b1;
      end
      OP_BNE: begin
        dec.alu_op = ALUOP_BNE;
        uses_rt    = 1'b1;
      end
      OP_BLEZ: dec.alu_op = ALUOP_BLEZ;
      OP_BGTZ: dec.alu_op = ALUOP_BGTZ;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec.alub_mux  = 1'b1;
        dec.reg_write = 1'b1;
        case (op)
          OP_ADDI:  dec.alu_op = ALUOP_ADDI;
          OP_ADDIU: dec.alu_op = ALUOP_ADDIU;
          OP_SLTI:  dec.alu_op = ALUOP_SLTI;
          OP_SLTIU: dec.alu_op = ALUOP_SLTIU;
          OP_ANDI:  dec.alu_op = ALUOP_ANDI;
          OP_ORI:   dec.alu_op = ALUOP_ORI;
          OP_XORI:  dec.alu_op = ALUOP_XORI;
          default:  dec.alu_op = ALUOP_LUI;
        endcase
      end
      OP_LB, OP_LH, OP_LW: begin
        dec.alub_mux   = 1'b1;
        dec.alu_op     = ALUOP_MEM;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = M2R_MEM;
        dec.reg_write  = 1'b1;
        dec.byte_sig   = (op == OP_LB) ? BS_BYTE : (op == OP_LH) ? BS_HALF : BS_WORD;
      end
      OP_SB, OP_SH, OP_SW: begin
        dec.alub_mux  = 1'b1;
        dec.alu_op    = ALUOP_MEM;
        dec.mem_write = 1'b1;
        uses_rt       = 1'b1;
        dec.byte_sig  = (op == OP_SB) ? BS_BYTE : (op == OP_SH) ? BS_HALF : BS_WORD;
      end
      OP_MADD: begin
        uses_rt       = 1'b1;
        dec.reg_dst   = REGDST_RD;
        dec.reg_write = 1'b1;
        case (funct)
          FUNC_MADD: dec.alu_op = ALUOP_MADD;
          FUNC_MSUB: dec.alu_op = ALUOP_MSUB;
          FUNC_MUL:  dec.alu_op = ALUOP_MUL;
          default:   dec_illegal = 1'b1;
        endcase
      end
      OP_SPECIAL3: begin
        dec.reg_dst   = REGDST_RD;
        dec.reg_write = 1'b1;
        if (ENABLE_EXT != 0 && funct == FUNC_BSHFL && sa == SA_SEB)
          dec.alu_op = ALUOP_SEB;
        else if (ENABLE_EXT != 0 && funct == FUNC_BSHFL && sa == SA_SEH)
          dec.alu_op = ALUOP_SEH;
        else
          dec_illegal = 1'b1;
      end
      OP_EXI, OP_LA: begin
        dec.alub_mux  = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = (op == OP_EXI) ? ALUOP_EXI : ALUOP_LA;
        if (ENABLE_EXT == 0) dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    dec.write_reg = (dec.reg_dst == REGDST_RD)  ? rd :
                    (dec.reg_dst == REGDST_R31) ? 5'd31 : rt;
  end

  assign is_mul = (op == OP_MADD) & ~dec_illegal;

  hazard_unit u_hazard (
    .rs           (rs),
    .rt           (rt),
    .uses_rt      (uses_rt),
    .ex_valid     (vld_p1),
    .ex_mem_read  (bundle_p1.mem_read),
    .ex_write_reg (bundle_p1.write_reg),
    .load_use     (raw_hazard)
  );

  assign load_use = (HAZARD_EN != 0) & (state == ST_RUN) & InstrValid_i & raw_hazard;
  // Flush and reset override any hold so the redirect target is fetched.
  assign stall    = ~Reset & ~Flush_i & ((state == ST_MUL_BUSY) | load_use);
  assign Stall_o  = stall;
  assign accept   = InstrValid_i & ~Flush_i & ~stall & (Instr_i != 32'd0);
  assign issue    = accept & ~dec_illegal;

  // ID/EX boundary
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bundle_p1  <= '0;
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      state      <= ST_RUN;
      mul_cnt    <= 4'd0;
    end else begin
      bundle_p1  <= issue ? dec : '0;
      vld_p1     <= issue;
      illegal_p1 <= accept & dec_illegal;
      if (Flush_i) begin
        state   <= ST_RUN;
        mul_cnt <= 4'd0;
      end else begin
        case (state)
          ST_RUN: begin
            if (issue && is_mul && MUL_CYCLES > 1) begin
              mul_cnt <= 4'(MUL_CYCLES - 1);
              state   <= ST_MUL_BUSY;
            end
          end
          default: begin
            mul_cnt <= mul_cnt - 4'd1;
            if (mul_cnt <= 4'd1) begin
              mul_cnt <= 4'd0;
              state   <= ST_RUN;
            end
          end
        endcase
      end
    end
  end

  assign Valid_o    = vld_p1;
  assign ALUBMux_o  = bundle_p1.alub_mux;
  assign RegDst_o   = bundle_p1.reg_dst;
  assign ALUOp_o    = ALUOP_W'(bundle_p1.alu_op);
  assign MemRead_o  = bundle_p1.mem_read;
  assign MemWrite_o = bundle_p1.mem_write;
  assign ByteSig_o  = bundle_p1.byte_sig;
  assign RegWrite_o = bundle_p1.reg_write;
  assign MemToReg_o = bundle_p1.mem_to_reg;
  assign Rs_o       = bundle_p1.rs;
  assign Rt_o       = bundle_p1.rt;
  assign WriteReg_o = bundle_p1.write_reg;
  assign Illegal_o  = illegal_p1;

endmodule

// File: tb/tb_id_control_stage.sv
// Directed bench for id_control_stage: one table row per clock, plus a
// hand-written reset-during-multiply sequence.
module tb_id_control_stage;
  import ctrl_defs::*;

  typedef struct packed {
    logic       valid;
    logic       alub;
    logic [1:0] regdst;
    logic [5:0] aluop;
    logic       mr;
    logic       mw;
    logic [1:0] bs;
    logic       rw;
    logic [1:0] m2r;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wr;
    logic       ill;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic        ivld;
    logic        flush;
    logic        stall;
    out_t        exp;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Instr_i = 32'd0;
  logic        InstrValid_i = 1'b0;
  logic        Flush_i = 1'b0;
  logic        Stall_o, Valid_o, ALUBMux_o, MemRead_o, MemWrite_o, RegWrite_o, Illegal_o;
  logic [1:0]  RegDst_o, ByteSig_o, MemToReg_o;
  logic [5:0]  ALUOp_o;
  logic [4:0]  Rs_o, Rt_o, WriteReg_o;

  int errors = 0;
  int checks = 0;
  vec_t vq[$];

  localparam logic [31:0] I_ADDIU = 32'h24080005;
  localparam logic [31:0] I_LW    = 32'h8D090000;
  localparam logic [31:0] I_MADD  = 32'h70430000;

  id_control_stage #(
    .ALUOP_W(6), .MUL_CYCLES(3), .ENABLE_EXT(0), .HAZARD_EN(1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Instr_i(Instr_i), .InstrValid_i(InstrValid_i),
    .Flush_i(Flush_i), .Stall_o(Stall_o), .Valid_o(Valid_o), .ALUBMux_o(ALUBMux_o),
    .RegDst_o(RegDst_o), .ALUOp_o(ALUOp_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ByteSig_o(ByteSig_o), .RegWrite_o(RegWrite_o),
    .MemToReg_o(MemToReg_o), .Rs_o(Rs_o), .Rt_o(Rt_o), .WriteReg_o(WriteReg_o),
    .Illegal_o(Illegal_o)
  );

  always #5 Clk = ~Clk;

  function automatic out_t sample();
    out_t o;
    o = {Valid_o, ALUBMux_o, RegDst_o, ALUOp_o, MemRead_o, MemWrite_o, ByteSig_o,
         RegWrite_o, MemToReg_o, Rs_o, Rt_o, WriteReg_o, Illegal_o};
    return o;
  endfunction

  function automatic out_t bv(int alub, int regdst, logic [5:0] aluop, int mr, int mw,
                              int bs, int rw, int m2r, int rs, int rt, int wr);
    out_t o;
    o        = '0;
    o.valid  = 1'b1;
    o.alub   = alub[0];
    o.regdst = regdst[1:0];
    o.aluop  = aluop;
    o.mr     = mr[0];
    o.mw     = mw[0];
    o.bs     = bs[1:0];
    o.rw     = rw[0];
    o.m2r    = m2r[1:0];
    o.rs     = rs[4:0];
    o.rt     = rt[4:0];
    o.wr     = wr[4:0];
    return o;
  endfunction

  function automatic out_t ilp();
    out_t o;
    o     = '0;
    o.ill = 1'b1;
    return o;
  endfunction

  function automatic vec_t mk(logic [31:0] instr, int ivld, int flush, int stall, out_t e);
    vec_t v;
    v.instr = instr;
    v.ivld  = ivld[0];
    v.flush = flush[0];
    v.stall = stall[0];
    v.exp   = e;
    return v;
  endfunction

  task automatic check_bit(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", nm, act, exp);
    end
  endtask

  task automatic check_out(string nm, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got bundle %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(int idx, vec_t v);
    Instr_i      = v.instr;
    InstrValid_i = v.ivld;
    Flush_i      = v.flush;
    #2;
    check_bit($sformatf("row%0d stall", idx), Stall_o, v.stall);
    @(posedge Clk);
    #1;
    check_out($sformatf("row%0d bundle", idx), sample(), v.exp);
  endtask

  initial begin
    out_t o_addiu, o_lw, o_madd;
    o_addiu = bv(1, 0, ALUOP_ADDIU, 0, 0, 0, 1, 0, 0, 8, 8);
    o_lw    = bv(1, 0, ALUOP_MEM,   1, 0, 0, 1, 1, 8, 9, 9);
    o_madd  = bv(0, 1, ALUOP_MADD,  0, 0, 0, 1, 0, 2, 3, 0);

    vq.push_back(mk(I_ADDIU,      1, 0, 0, o_addiu));
    vq.push_back(mk(I_LW,         1, 0, 0, o_lw));
    vq.push_back(mk(32'h012B5020, 1, 0, 1, '0));
    vq.push_back(mk(32'h012B5020, 1, 0, 0, bv(0, 1, ALUOP_ADD, 0, 0, 0, 1, 0, 9, 11, 10)));
    vq.push_back(mk(I_LW,         1, 0, 0, o_lw));
    vq.push_back(mk(32'hAC490004, 1, 0, 1, '0));
    vq.push_back(mk(32'hAC490004, 1, 0, 0, bv(1, 0, ALUOP_MEM, 0, 1, 0, 0, 0, 2, 9, 9)));
    vq.push_back(mk(32'h81090000, 1, 0, 0, bv(1, 0, ALUOP_MEM, 1, 0, 2, 1, 1, 8, 9, 9)));
    vq.push_back(mk(32'h34690007, 1, 0, 0, bv(1, 0, ALUOP_ORI, 0, 0, 0, 1, 0, 3, 9, 9)));
    vq.push_back(mk(32'h84200002, 1, 0, 0, bv(1, 0, ALUOP_MEM, 1, 0, 1, 1, 1, 1, 0, 0)));
    vq.push_back(mk(32'h00001020, 1, 0, 0, bv(0, 1, ALUOP_ADD, 0, 0, 0, 1, 0, 0, 0, 2)));
    vq.push_back(mk(32'h0C000010, 1, 0, 0, bv(0, 2, ALUOP_JUMP, 0, 0, 0, 1, 2, 0, 0, 31)));
    vq.push_back(mk(32'h00000000, 1, 0, 0, '0));
    vq.push_back(mk(I_ADDIU,      0, 0, 0, '0));
    vq.push_back(mk(I_ADDIU,      1, 1, 0, '0));
    vq.push_back(mk(32'h10220003, 1, 0, 0, bv(0, 0, ALUOP_BEQ,  0, 0, 0, 0, 0, 1, 2, 2)));
    vq.push_back(mk(32'h04A00008, 1, 0, 0, bv(0, 0, ALUOP_BLTZ, 0, 0, 0, 0, 0, 5, 0, 0)));
    vq.push_back(mk(32'h04A10008, 1, 0, 0, bv(0, 0, ALUOP_BGEZ, 0, 0, 0, 0, 0, 5, 1, 1)));
    vq.push_back(mk(32'h00041882, 1, 0, 0, bv(0, 1, ALUOP_SRL,  0, 0, 0, 1, 0, 0, 4, 3)));
    vq.push_back(mk(32'h00241882, 1, 0, 0, bv(0, 1, ALUOP_ROTR, 0, 0, 0, 1, 0, 1, 4, 3)));
    vq.push_back(mk(32'hFC000000, 1, 0, 0, ilp()));
    vq.push_back(mk(32'h74000000, 1, 0, 0, ilp()));
    vq.push_back(mk(32'h7C000420, 1, 0, 0, ilp()));
    // MADD occupancy: two held cycles, follower issues on the third
    vq.push_back(mk(I_MADD,       1, 0, 0, o_madd));
    vq.push_back(mk(I_ADDIU,      1, 0, 1, '0));
    vq.push_back(mk(I_ADDIU,      1, 0, 1, '0));
    vq.push_back(mk(I_ADDIU,      1, 0, 0, o_addiu));
    // load-use on a MADD: hold once, then the MADD issues and occupies
    vq.push_back(mk(I_LW,         1, 0, 0, o_lw));
    vq.push_back(mk(32'h71230000, 1, 0, 1, '0));
    vq.push_back(mk(32'h71230000, 1, 0, 0, bv(0, 1, ALUOP_MADD, 0, 0, 0, 1, 0, 9, 3, 0)));
    vq.push_back(mk(I_ADDIU,      1, 0, 1, '0));
    vq.push_back(mk(I_ADDIU,      1, 0, 1, '0));
    vq.push_back(mk(I_ADDIU,      1, 0, 0, o_addiu));
    // flush on the first busy cycle ends the occupancy
    vq.push_back(mk(I_MADD,       1, 0, 0, o_madd));
    vq.push_back(mk(I_ADDIU,      1, 1, 0, '0));
    vq.push_back(mk(I_ADDIU,      1, 0, 0, o_addiu));

    // reset state, with a valid instruction presented during reset
    Reset        = 1'b1;
    Instr_i      = I_ADDIU;
    InstrValid_i = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check_bit("reset stall", Stall_o, 1'b0);
    check_out("reset bundle", sample(), '0);
    Reset        = 1'b0;
    InstrValid_i = 1'b0;

    for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

    // reset issued while the multiplier holds the front end
    Instr_i      = I_MADD;
    InstrValid_i = 1'b1;
    Flush_i      = 1'b0;
    @(posedge Clk);
    #1;
    check_out("rst-busy madd", sample(), o_madd);
    Instr_i = I_ADDIU;
    #2;
    check_bit("rst-busy held", Stall_o, 1'b1);
    Reset = 1'b1;
    #1;
    check_bit("rst-busy stall in reset", Stall_o, 1'b0);
    @(posedge Clk);
    #1;
    check_out("rst-busy cleared", sample(), '0);
    Reset = 1'b0;
    #2;
    check_bit("rst-busy back to run", Stall_o, 1'b0);
    @(posedge Clk);
    #1;
    check_out("rst-busy next issue", sample(), o_addiu);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_control_stage.md
Name: id_control_stage

Overview:
- Registered successor to the combinational instruction decoder.
- Decodes the IF/ID instruction into the full control bundle and registers it into the ID/EX boundary.
- Adds load-use hazard detection, a multi-cycle MUL/MADD/MSUB occupancy counter, flush/bubble insertion and illegal-opcode flagging.
- Sits between the IF/ID register and the execute stage; drives the PC/IF-ID freeze.

Parameters:
- ALUOP_W, 6: width of ALUOp; encodings come from the shared package and are zero-extended when ALUOP_W > 6.
- MUL_CYCLES, 3: execute occupancy of MUL/MADD/MSUB, range 1..15; a value of 1 means no extra stall.
- ENABLE_EXT, 1: when 1, decode SEB/SEH/EXI/LA; when 0, those opcodes are illegal.
- HAZARD_EN, 1: when 0, load-use detection is disabled and Stall_o comes from MUL only.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Instr_i  in  32  instruction from IF/ID.
- InstrValid_i  in  1  Instr_i holds a real instruction.
- Flush_i  in  1  squash the instruction in decode (taken branch/jump).
- Stall_o  out  1  combinational; freeze PC and IF/ID this cycle.
- Valid_o  out  1  registered; the bundle is a real instruction.
- ALUBMux_o  out  1  registered; ALU operand B is the immediate.
- RegDst_o  out  2  registered; 00 rt, 01 rd, 10 r31.
- ALUOp_o  out  ALUOP_W  registered.
- MemRead_o / MemWrite_o  out  1 each  registered.
- ByteSig_o  out  2  registered; 00 word, 01 half, 10 byte.
- RegWrite_o  out  1  registered.
- MemToReg_o  out  2  registered; 00 ALU, 01 memory, 10 PC+8.
- Rs_o / Rt_o / WriteReg_o  out  5 each  registered register indices.
- Illegal_o  out  1  registered one-cycle pulse.

Behaviour:
- Reset: every registered output is 0, state is RUN, mul_cnt is 0. Stall_o is 0 during the reset cycle. Reset issued mid-MUL_BUSY aborts the busy period.
- Latency: an instruction accepted at edge N (InstrValid_i=1, Stall_o=0, Flush_i=0) presents its bundle after edge N+1.
- Bubble: Valid_o=0 and RegWrite/MemRead/MemWrite=0. Other fields are 0.
- Bubble triggers: Flush_i, Stall_o, InstrValid_i=0, Instr_i==0 (NOP), and illegal opcodes.
- Decode rules:
  - ALUBMux=1 for ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU/LUI/loads/stores/EXI/LA.
  - RegDst=01 for R-type/MADD/SEB/SEH; RegDst=10 for JAL.
  - RegWrite=0 for JR, J, branches and stores.
  - Loads: MemRead=1, MemToReg=01. JAL: MemToReg=10.
  - ByteSig from LB/SB=10, LH/SH=01, else 00.
  - BGEZ vs BLTZ selected by Instr[16]. SEB/SEH selected by Instr[10:6]. SRL vs ROTR selected by Instr[21]. SRLV vs ROTRV selected by Instr[6].
  - Unlisted opcodes set Illegal_o.
- WriteReg_o = rt, rd or 31 according to RegDst.
- State machine: RUN, MUL_BUSY.
- Load-use hazard (RUN, HAZARD_EN=1):
  - Condition: Valid_o & MemRead_o & WriteReg_o!=0, and WriteReg_o equals decode rs, or equals decode rt when the decode instruction reads rt (R-type, MADD, BEQ/BNE, stores).
  - Response: Stall_o=1 for exactly one cycle and a bubble is issued. The same Instr_i is re-decoded on the next cycle.
- MUL occupancy:
  - On issue of OP_MADD with MUL_CYCLES>1: load mul_cnt=MUL_CYCLES-1 and go to MUL_BUSY.
  - In MUL_BUSY: Stall_o=1, bubbles are issued, mul_cnt decrements each cycle. Return to RUN when mul_cnt==1 is decremented.
  - Result: exactly MUL_CYCLES-1 stall cycles.
- Flush_i:
  - Priority: highest below Reset.
  - Next bundle is a bubble.
  - Forces RUN and clears mul_cnt.
  - Stall_o=0 in the flush cycle.
- Simultaneous events: a load-use condition on an OP_MADD instruction stalls first; the MADD issues one cycle later.
- Illegal_o pulses with the bubble edge and does not stall.

Decomposition:
- Shared package/header (ctrl_defs):
  - OP_* and FUNC_* constants.
  - ALUOP_* encodings.
  - RegDst, ByteSig and MemToReg encodings.
- Sub-module hazard_unit: purely combinational load-use compare. Inputs are decode rs/rt/uses-rt and the EX-side Valid/MemRead/WriteReg; output is the load-use stall.
- Decode logic and the state machine stay in the top-level module.

Test Plan:
- Reset mid-MUL_BUSY: Reset=1 during a busy cycle -> next cycle all outputs 0, Stall_o=0, state RUN.
- ADDIU $8,$0,5 (0x24080005), then LW $9,0($8) (0x8D090000): bundles appear one cycle after each accept.
  - ADDIU: ALUBMux=1, ALUOp=ALUOP_ADDIU, WriteReg=8, RegWrite=1.
  - LW: MemRead=1, MemToReg=01, ByteSig=00, WriteReg=9.
- LW $9,0($8) followed by ADD $10,$9,$11 (0x012B5020): Stall_o=1 for one cycle and one bubble. ADD then issues with RegDst=01, WriteReg=10.
- MADD (opcode 0x1C) with MUL_CYCLES=3: issue, then Stall_o=1 for 2 cycles with Valid_o=0. The next instruction issues on cycle 4.
- MADD, then Flush_i on the first busy cycle: bubble, Stall_o=0 from that cycle, state RUN.
- Opcode 0x3F with ENABLE_EXT=0, and LA (0x1D) with ENABLE_EXT=0: Illegal_o pulses once for each, Valid_o=0.
- JAL (0x0C000010): RegDst=10, WriteReg=31, MemToReg=10, RegWrite=1, ALUOp=ALUOP_JUMP.
